// File: rtl/scan_sequencer.sv
// Film scanner scan controller: driver wake, optional carriage homing, then a step/settle/capture loop per line.
// Homing is compiled in only when SCAN_HOME_EN is defined; otherwise WAKE proceeds straight to SETTLE_H.
module scan_sequencer #(
    parameter int STEP_HALF  = 50000,
    parameter int SETTLE_CYC = 100000,
    parameter int HOME_MAX   = 20000
) (
    input  logic        clk_100M,
    input  logic        nrst,
    input  logic        start,
    input  logic        abort,
    input  logic [15:0] n_lines,
    input  logic [7:0]  steps_per_line,
    input  logic        dir_fwd,
    input  logic        mtr_nhome,
    input  logic        mtr_nflt,
    input  logic        line_done,
    output logic        mtr_step,
    output logic        mtr_dir,
    output logic        mtr_nen,
    output logic        mtr_slp,
    output logic        mtr_nrst,
    output logic        line_req,
    output logic        led_on,
    output logic        busy,
    output logic        done,
    output logic        fault,
    output logic [15:0] line_cnt
);
    localparam logic [3:0] ST_IDLE     = 4'd0;
    localparam logic [3:0] ST_WAKE     = 4'd1;
    localparam logic [3:0] ST_HOME     = 4'd2;
    localparam logic [3:0] ST_SETTLE_H = 4'd3;
    localparam logic [3:0] ST_STEP     = 4'd4;
    localparam logic [3:0] ST_SETTLE   = 4'd5;
    localparam logic [3:0] ST_CAPTURE  = 4'd6;
    localparam logic [3:0] ST_DONE     = 4'd7;
    localparam logic [3:0] ST_FAULT    = 4'd8;

    localparam logic [31:0] SETTLE_LAST = 32'(SETTLE_CYC - 1);
    localparam logic [31:0] HALF_CYC    = 32'(STEP_HALF);
    localparam logic [31:0] STEP_LAST   = 32'(2 * STEP_HALF - 1);
`ifdef SCAN_HOME_EN
    localparam logic [31:0] HALF_LAST   = 32'(STEP_HALF - 1);
    localparam logic [31:0] HOME_LAST   = 32'(HOME_MAX - 1);
`else
    localparam int          unused_home_max = HOME_MAX;
`endif

    logic [3:0]  state_r, state_nxt_s;
    logic [31:0] cnt_r, cnt_nxt_s;
    logic [31:0] ph_r, ph_nxt_s;
    logic [7:0]  step_cnt_r, step_cnt_nxt_s;
    logic [15:0] lines_r, lines_nxt_s;
    logic [7:0]  spl_r, spl_nxt_s;
    logic        dir_fwd_r, dir_fwd_nxt_s;
    logic [15:0] line_cnt_r, line_cnt_nxt_s;
    logic [15:0] line_inc_s;
    logic        nflt_meta_r, nflt_sync_r;
    logic        mtr_step_r, mtr_dir_r, mtr_nen_r, mtr_slp_r, mtr_nrst_r;
    logic        line_req_r, led_on_r, busy_r, done_r, fault_r;
    logic        drv_on_s, step_nxt_s, dir_nxt_s, line_req_nxt_s, done_nxt_s;
`ifdef SCAN_HOME_EN
    logic        nhome_meta_r, nhome_sync_r;
    logic [31:0] home_cnt_r, home_cnt_nxt_s;
`else
    logic        unused_nhome_s;
    assign unused_nhome_s = mtr_nhome;
`endif

    function automatic logic is_busy(input logic [3:0] st);
        return (st != ST_IDLE) && (st != ST_FAULT);
    endfunction

    // Driver and backlight are powered in every scanning state; DONE already returns them to idle
    function automatic logic drive_on(input logic [3:0] st);
        case (st)
            ST_WAKE, ST_HOME, ST_SETTLE_H, ST_STEP, ST_SETTLE, ST_CAPTURE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Two-flop synchroniser for the asynchronous driver fault input
    always_ff @(posedge clk_100M or negedge nrst) begin
        if (!nrst) begin
            nflt_meta_r <= 1'b1;
            nflt_sync_r <= 1'b1;
        end else begin
            nflt_meta_r <= mtr_nflt;
            nflt_sync_r <= nflt_meta_r;
        end
    end

`ifdef SCAN_HOME_EN
    // Two-flop synchroniser for the asynchronous home switch input
    always_ff @(posedge clk_100M or negedge nrst) begin
        if (!nrst) begin
            nhome_meta_r <= 1'b1;
            nhome_sync_r <= 1'b1;
        end else begin
            nhome_meta_r <= mtr_nhome;
            nhome_sync_r <= nhome_meta_r;
        end
    end
`endif

    assign line_inc_s = line_cnt_r + 16'd1;

    // Next-state and counter logic; abort outranks a driver fault, which outranks normal sequencing
    always_comb begin
        state_nxt_s    = state_r;
        cnt_nxt_s      = cnt_r;
        ph_nxt_s       = ph_r;
        step_cnt_nxt_s = step_cnt_r;
        lines_nxt_s    = lines_r;
        spl_nxt_s      = spl_r;
        dir_fwd_nxt_s  = dir_fwd_r;
        line_cnt_nxt_s = line_cnt_r;
`ifdef SCAN_HOME_EN
        home_cnt_nxt_s = home_cnt_r;
`endif
        if (abort) begin
            state_nxt_s = ST_IDLE;
        end else if (is_busy(state_r) && !nflt_sync_r) begin
            state_nxt_s = ST_FAULT;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        lines_nxt_s    = n_lines;
                        spl_nxt_s      = steps_per_line;
                        dir_fwd_nxt_s  = dir_fwd;
                        line_cnt_nxt_s = 16'd0;
                        cnt_nxt_s      = 32'd0;
                        state_nxt_s    = ST_WAKE;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_WAKE: begin
                    if (cnt_r == SETTLE_LAST) begin
                        cnt_nxt_s = 32'd0;
                        ph_nxt_s  = 32'd0;
`ifdef SCAN_HOME_EN
                        home_cnt_nxt_s = 32'd0;
                        state_nxt_s    = ST_HOME;
`else
                        state_nxt_s    = ST_SETTLE_H;
`endif
                    end else begin
                        cnt_nxt_s = cnt_r + 32'd1;
                    end
                end
`ifdef SCAN_HOME_EN
                // The switch is judged at the end of each low phase, so a found home emits no further pulse
                ST_HOME: begin
                    if ((ph_r == HALF_LAST) && !nhome_sync_r) begin
                        state_nxt_s = ST_SETTLE_H;
                        cnt_nxt_s   = 32'd0;
                        ph_nxt_s    = 32'd0;
                    end else if (ph_r == STEP_LAST) begin
                        ph_nxt_s = 32'd0;
                        if (home_cnt_r == HOME_LAST) begin
                            state_nxt_s = ST_FAULT;
                        end else begin
                            home_cnt_nxt_s = home_cnt_r + 32'd1;
                        end
                    end else begin
                        ph_nxt_s = ph_r + 32'd1;
                    end
                end
`endif
                ST_SETTLE_H: begin
                    if (cnt_r == SETTLE_LAST) begin
                        cnt_nxt_s      = 32'd0;
                        ph_nxt_s       = 32'd0;
                        step_cnt_nxt_s = 8'd0;
                        if (lines_r == 16'd0) begin
                            state_nxt_s = ST_DONE;
                        end else begin
                            state_nxt_s = ST_STEP;
                        end
                    end else begin
                        cnt_nxt_s = cnt_r + 32'd1;
                    end
                end
                // The exit decision takes one low cycle after the last pulse, before SETTLE starts counting
                ST_STEP: begin
                    if ((ph_r == 32'd0) && (step_cnt_r == spl_r)) begin
                        state_nxt_s = ST_SETTLE;
                        cnt_nxt_s   = 32'd0;
                    end else if (ph_r == STEP_LAST) begin
                        ph_nxt_s       = 32'd0;
                        step_cnt_nxt_s = step_cnt_r + 8'd1;
                    end else begin
                        ph_nxt_s = ph_r + 32'd1;
                    end
                end
                ST_SETTLE: begin
                    if (cnt_r == SETTLE_LAST) begin
                        state_nxt_s = ST_CAPTURE;
                    end else begin
                        cnt_nxt_s = cnt_r + 32'd1;
                    end
                end
                ST_CAPTURE: begin
                    if (line_done) begin
                        line_cnt_nxt_s = line_inc_s;
                        ph_nxt_s       = 32'd0;
                        step_cnt_nxt_s = 8'd0;
                        if (line_inc_s == lines_r) begin
                            state_nxt_s = ST_DONE;
                        end else begin
                            state_nxt_s = ST_STEP;
                        end
                    end else begin
                        state_nxt_s = ST_CAPTURE;
                    end
                end
                ST_DONE:  state_nxt_s = ST_IDLE;
                ST_FAULT: state_nxt_s = ST_FAULT;
                default:  state_nxt_s = ST_IDLE;
            endcase
        end
    end

    // Output values for the coming cycle, derived from the next state so outputs stay registered
    always_comb begin
        drv_on_s   = drive_on(state_nxt_s);
        step_nxt_s = 1'b0;
        dir_nxt_s  = mtr_dir_r;
        if (((state_nxt_s == ST_STEP) || (state_nxt_s == ST_HOME)) && (ph_nxt_s >= HALF_CYC)) begin
            step_nxt_s = 1'b1;
        end else begin
            step_nxt_s = 1'b0;
        end
        if (state_nxt_s == ST_HOME) begin
            dir_nxt_s = !dir_fwd_r;
        end else if (state_nxt_s == ST_STEP) begin
            dir_nxt_s = dir_fwd_r;
        end else begin
            dir_nxt_s = mtr_dir_r;
        end
        line_req_nxt_s = (state_nxt_s == ST_CAPTURE) && (state_r != ST_CAPTURE);
        done_nxt_s     = (state_r == ST_DONE) && (state_nxt_s == ST_IDLE) && !abort;
    end

    // State, counters and registered outputs
    always_ff @(posedge clk_100M or negedge nrst) begin
        if (!nrst) begin
            state_r    <= ST_IDLE;
            cnt_r      <= 32'd0;
            ph_r       <= 32'd0;
            step_cnt_r <= 8'd0;
            lines_r    <= 16'd0;
            spl_r      <= 8'd0;
            dir_fwd_r  <= 1'b0;
            line_cnt_r <= 16'd0;
`ifdef SCAN_HOME_EN
            home_cnt_r <= 32'd0;
`endif
            mtr_step_r <= 1'b0;
            mtr_dir_r  <= 1'b0;
            mtr_nen_r  <= 1'b1;
            mtr_slp_r  <= 1'b0;
            mtr_nrst_r <= 1'b0;
            line_req_r <= 1'b0;
            led_on_r   <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            fault_r    <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            cnt_r      <= cnt_nxt_s;
            ph_r       <= ph_nxt_s;
            step_cnt_r <= step_cnt_nxt_s;
            lines_r    <= lines_nxt_s;
            spl_r      <= spl_nxt_s;
            dir_fwd_r  <= dir_fwd_nxt_s;
            line_cnt_r <= line_cnt_nxt_s;
`ifdef SCAN_HOME_EN
            home_cnt_r <= home_cnt_nxt_s;
`endif
            mtr_step_r <= step_nxt_s;
            mtr_dir_r  <= dir_nxt_s;
            mtr_nen_r  <= !drv_on_s;
            mtr_slp_r  <= drv_on_s;
            mtr_nrst_r <= drv_on_s;
            line_req_r <= line_req_nxt_s;
            led_on_r   <= drv_on_s;
            busy_r     <= is_busy(state_nxt_s);
            done_r     <= done_nxt_s;
            fault_r    <= (state_nxt_s == ST_FAULT);
        end
    end

    assign mtr_step = mtr_step_r;
    assign mtr_dir  = mtr_dir_r;
    assign mtr_nen  = mtr_nen_r;
    assign mtr_slp  = mtr_slp_r;
    assign mtr_nrst = mtr_nrst_r;
    assign line_req = line_req_r;
    assign led_on   = led_on_r;
    assign busy     = busy_r;
    assign done     = done_r;
    assign fault    = fault_r;
    assign line_cnt = line_cnt_r;

endmodule
